// File: rtl/od_rx_pkg.sv
// Shared defaults and counter-width helpers for the open-drain line receiver.
package od_rx_pkg;

  localparam int OD_RX_CHANNELS = 6;
  localparam int OD_RX_FILTER   = 4;
  localparam int OD_RX_STUCK    = 1024;

  // Filter counter must hold FILTER-1 with headroom; one extra bit keeps FILTER=1 legal.
  function automatic int od_rx_cnt_width(input int filter);
    return $clog2(filter) + 1;
  endfunction

  // Stuck counter must hold STUCK itself; STUCK=0 still needs a 1-bit register.
  function automatic int od_rx_sc_width(input int stuck);
    return (stuck < 1) ? 1 : $clog2(stuck + 1);
  endfunction

endpackage

// File: rtl/od_rx_chan.sv
// One open-drain line: pull-up resolve, two-flop synchronizer, run-length
// deglitch filter, registered edge strobes and saturating stuck-low detection.
module od_rx_chan
  import od_rx_pkg::*;
#(
  parameter int FILTER = OD_RX_FILTER,
  parameter int STUCK  = OD_RX_STUCK
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stuck_low
);

  localparam int CW = od_rx_cnt_width(FILTER);
  localparam int SW = od_rx_sc_width(STUCK);

  logic          w_raw;
  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sc;
  logic          r_rise;
  logic          r_fall;

  // Only an explicit low pulls the line down; z and x read as the idle pull-up.
  assign w_raw = (line === 1'b0) ? 1'b0 : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_cnt     <= '0;
      r_sc      <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;

      // Any agreeing sample restarts qualification, so short runs leave no trace.
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      r_fall    <= ~r_level & r_level_d;

      if (r_level) begin
        r_sc <= '0;
      end else if (r_sc != SW'(STUCK)) begin
        r_sc <= r_sc + 1'b1;
      end
    end
  end

  assign level     = r_level;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign stuck_low = (STUCK != 0) && (r_sc == SW'(STUCK));

endmodule

// File: rtl/od_line_receiver.sv
// Receiver for up to six pulled-up wired-OR lines; each channel is an
// independent od_rx_chan, so simultaneous events strobe together.
module od_line_receiver
  import od_rx_pkg::*;
#(
  parameter int CHANNELS = OD_RX_CHANNELS,
  parameter int FILTER   = OD_RX_FILTER,
  parameter int STUCK    = OD_RX_STUCK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] line,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] stuck_low
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    od_rx_chan #(
      .FILTER(FILTER),
      .STUCK (STUCK)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .line     (line[g]),
      .level    (level[g]),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .stuck_low(stuck_low[g])
    );
  end

endmodule
